// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit processor: FSM states, opcodes, default widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 8;

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment; increment wraps modulo 2**ADDR_W.
module program_counter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (en) begin
      if (load) begin
        pc <= load_val;
      end else if (inc) begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing stage: FETCH -> DECODE -> EXEC/HALT, resolving JMP, JC and HLT locally.
// Build option FETCH_COND_JUMP_EN: when defined, opcode 4'hC is a carry-conditional jump.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [INSTR_W-1:0] ram_data,
  input  logic               carry,
  input  logic               exec_ready,
  output logic               exec_valid,
  output logic [3:0]         opcode,
  output logic [3:0]         operand,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  state_t             state, state_nx;
  logic [INSTR_W-1:0] ir;
  logic               ir_ld;
  logic               pc_load;
  logic               pc_inc;

  assign opcode     = ir[INSTR_W-1 -: 4];
  assign operand    = ir[3:0];
  assign exec_valid = (state == EXEC);
  assign halted     = (state == HALT);
  assign ram_addr   = pc;

`ifndef FETCH_COND_JUMP_EN
  logic unused_carry;
  assign unused_carry = carry;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      ir    <= '0;
    end else if (en) begin
      state <= state_nx;
      if (ir_ld) begin
        ir <= ram_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ir_ld    = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    case (state)
      FETCH: begin
        ir_ld    = 1'b1;
        state_nx = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_JMP: begin
            pc_load  = 1'b1;
            state_nx = FETCH;
          end
`ifdef FETCH_COND_JUMP_EN
          OP_JC: begin
            pc_load  = carry;
            pc_inc   = !carry;
            state_nx = FETCH;
          end
`endif
          OP_HLT:  state_nx = HALT;
          default: state_nx = EXEC;
        endcase
      end
      EXEC: begin
        // en gating of the handshake comes from the state/pc register enables
        if (exec_ready) begin
          pc_inc   = 1'b1;
          state_nx = FETCH;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  program_counter #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (pc_load),
    .load_val (ADDR_W'(operand)),
    .inc      (pc_inc),
    .pc       (pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational program-RAM model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       carry;
  logic       exec_ready;
  logic       exec_valid;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [3:0] pc;
  logic       halted;

  logic [7:0] mem [16];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ram_data = mem[ram_addr];

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .carry      (carry),
    .exec_ready (exec_ready),
    .exec_valid (exec_valid),
    .opcode     (opcode),
    .operand    (operand),
    .pc         (pc),
    .halted     (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Pulse reset between clock edges; the next edge is the first FETCH edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = 8'h5A;
    rst_n = 1'b0;
    step();
    n_checks++; if (pc !== 4'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
    n_checks++; if (ram_addr !== 4'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", ram_addr); end
    n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", exec_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_checks++; if ({opcode, operand} !== 8'h00) begin n_fail++; $display("FAIL reset_ir got %h want 00", {opcode, operand}); end
    rst_n = 1'b1;
  endtask

  task automatic test_ordinary();
    clear_mem();
    mem[0] = 8'h08;
    exec_ready = 1'b1;
    apply_reset();
    n_checks++; if (ram_addr !== 4'h0) begin n_fail++; $display("FAIL ord_addr got %h want 0", ram_addr); end
    step();
    n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL ord_valid_c2 got %b want 0", exec_valid); end
    step();
    n_checks++; if (exec_valid !== 1'b1) begin n_fail++; $display("FAIL ord_valid_c3 got %b want 1", exec_valid); end
    n_checks++; if (opcode !== 4'h0 || operand !== 4'h8) begin n_fail++; $display("FAIL ord_ir got %h%h want 08", opcode, operand); end
    n_checks++; if (pc !== 4'h0) begin n_fail++; $display("FAIL ord_pc_c3 got %h want 0", pc); end
    step();
    n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL ord_valid_c4 got %b want 0", exec_valid); end
    n_checks++; if (pc !== 4'h1) begin n_fail++; $display("FAIL ord_pc_c4 got %h want 1", pc); end
  endtask

  task automatic test_jump();
    clear_mem();
    mem[0] = 8'hB9;
    mem[9] = 8'hB3;
    exec_ready = 1'b1;
    apply_reset();
    step();
    step();
    n_checks++; if (ram_addr !== 4'h9) begin n_fail++; $display("FAIL jmp_addr9 got %h want 9", ram_addr); end
    step();
    n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_valid got %b want 0", exec_valid); end
    step();
    n_checks++; if (pc !== 4'h3) begin n_fail++; $display("FAIL jmp_pc got %h want 3", pc); end
  endtask

  task automatic test_jc();
    clear_mem();
    mem[0] = 8'hC5;
    exec_ready = 1'b0;
    carry = 1'b1;
    apply_reset();
    step();
    step();
    carry = 1'b0;
`ifdef FETCH_COND_JUMP_EN
    n_checks++; if (pc !== 4'h5) begin n_fail++; $display("FAIL jc_taken_pc got %h want 5", pc); end
    n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL jc_taken_valid got %b want 0", exec_valid); end
    apply_reset();
    step();
    step();
    n_checks++; if (pc !== 4'h1) begin n_fail++; $display("FAIL jc_untaken_pc got %h want 1", pc); end
    n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL jc_untaken_valid got %b want 0", exec_valid); end
`else
    n_checks++; if (exec_valid !== 1'b1) begin n_fail++; $display("FAIL jc_plain_valid got %b want 1", exec_valid); end
    n_checks++; if (pc !== 4'h0) begin n_fail++; $display("FAIL jc_plain_pc got %h want 0", pc); end
`endif
  endtask

  task automatic test_stall();
    clear_mem();
    mem[0] = 8'h27;
    exec_ready = 1'b0;
    apply_reset();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (exec_valid !== 1'b1 || {opcode, operand} !== 8'h27 || pc !== 4'h0) begin
        n_fail++; $display("FAIL stall_hold%0d got v=%b ir=%h%h pc=%h want v=1 ir=27 pc=0", i, exec_valid, opcode, operand, pc);
      end
    end
    exec_ready = 1'b1;
    en = 1'b0;
    step();
    n_checks++; if (exec_valid !== 1'b1 || pc !== 4'h0) begin
      n_fail++; $display("FAIL stall_en0 got v=%b pc=%h want v=1 pc=0", exec_valid, pc);
    end
    en = 1'b1;
    step();
    n_checks++; if (pc !== 4'h1) begin n_fail++; $display("FAIL stall_release_pc got %h want 1", pc); end
    n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid got %b want 0", exec_valid); end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0]  = 8'hBF;
    mem[15] = 8'h01;
    exec_ready = 1'b1;
    apply_reset();
    step();
    step();
    n_checks++; if (pc !== 4'hF) begin n_fail++; $display("FAIL wrap_pre_pc got %h want f", pc); end
    step();
    step();
    step();
    n_checks++; if (pc !== 4'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", pc); end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = 8'hF0;
    exec_ready = 1'b1;
    apply_reset();
    step();
    step();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got %b want 1", halted); end
    n_checks++; if (exec_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid got %b want 0", exec_valid); end
    for (int i = 0; i < 3; i++) step();
    n_checks++; if (halted !== 1'b1 || pc !== 4'h0) begin
      n_fail++; $display("FAIL halt_hold got h=%b pc=%h want h=1 pc=0", halted, pc);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset got %b want 0", halted); end
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    clear_mem();
    mem[0] = 8'hB4;
    mem[4] = 8'h3A;
    exec_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (exec_valid !== 1'b1 || pc !== 4'h4) begin
      n_fail++; $display("FAIL arst_pre got v=%b pc=%h want v=1 pc=4", exec_valid, pc);
    end
    rst_n = 1'b0;
    #2;
    n_checks++; if (exec_valid !== 1'b0 || pc !== 4'h0 || {opcode, operand} !== 8'h00) begin
      n_fail++; $display("FAIL arst_mid got v=%b pc=%h ir=%h%h want v=0 pc=0 ir=00", exec_valid, pc, opcode, operand);
    end
    rst_n = 1'b1;
    step();
    n_checks++; if (opcode !== 4'hB || operand !== 4'h4) begin
      n_fail++; $display("FAIL arst_refetch got %h%h want b4", opcode, operand);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    carry      = 1'b0;
    exec_ready = 1'b0;
    test_reset();
    test_ordinary();
    test_jump();
    test_jc();
    test_stall();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and sequencing stage of the 4-bit processor. Holds the program counter, drives the 4-bit address into the combinational program RAM, latches the returned 8-bit instruction into the instruction register, and resolves jumps and halt locally. Non-control instructions go to the execute stage over a valid/ready handshake.

## Interface
- `ADDR_W`, default 4, program-counter and RAM address width
- `INSTR_W`, default 8, instruction width: opcode is `[7:4]`, operand is `[3:0]`
- `clk  in  1`  system clock
- `rst_n  in  1`  reset, asynchronous and active-low
- `en  in  1`  step enable from the board clock divider; all state changes are gated by it
- `ram_addr  out  ADDR_W`  address to program RAM; equals `pc`
- `ram_data  in  INSTR_W`  instruction returned combinationally by program RAM
- `carry  in  1`  carry flag from the ALU, used by JC
- `exec_ready  in  1`  execute stage accepts the instruction
- `exec_valid  out  1`  the instruction register holds an instruction for execute
- `opcode  out  4`  `ir[7:4]`
- `operand  out  4`  `ir[3:0]`
- `pc  out  ADDR_W`  current program counter
- `halted  out  1`  HLT has been executed

## Operation
- States:
  - FETCH: capture `ir <= ram_data`, then go to DECODE.
  - DECODE:
    - JMP (`4'hB`): `pc <= operand`, go to FETCH.
    - JC (`4'hC`): if `carry`, `pc <= operand`; otherwise `pc <= pc+1`. Go to FETCH.
    - HLT (`4'hF`): go to HALT.
    - Any other opcode: go to EXEC.
  - EXEC: hold `exec_valid=1` and keep `ir` stable. On `exec_ready && en`, `pc <= pc+1` and go to FETCH.
  - HALT: `halted=1`. The state is terminal; only reset leaves it.
- PC increment is modulo 16: `4'hF + 1` gives `4'h0`, with no flag.
- Jumps, JC and HLT never assert `exec_valid`.
- `carry` is sampled only in the DECODE cycle.
- Reset values: `pc=0`, `ir=8'h00`, state FETCH, `exec_valid=0`, `halted=0`, `ram_addr=0`.

## Timing
- `ram_addr` is registered (it equals `pc`). RAM data is valid within the same cycle and is captured at the FETCH clock edge.
- Ordinary instruction: FETCH 1 cycle, DECODE 1 cycle, EXEC 1 or more cycles. The minimum is 3 enabled cycles per instruction.
- `exec_valid` rises on the first EXEC cycle. If `exec_ready` is already high, the handshake completes at the end of that cycle and `exec_valid` drops the next cycle.
- Taken jump, untaken JC, and HLT each take 2 enabled cycles.
- `en=0`: state, `pc`, `ir` and `exec_valid` all freeze. A pending handshake does not complete while `en=0`, even if `exec_ready=1`.
- `exec_ready` outside EXEC is ignored.
- Reset is asynchronous and mid-operation: all outputs return to their reset values immediately, and fetch restarts at address 0 after `rst_n` deasserts.
- Jump to the current address is legal and loops forever; it has no special case.

## Configuration
- `FETCH_COND_JUMP_EN`
  - Defined: opcode `4'hC` is JC and is resolved in DECODE as above.
  - Undefined: `4'hC` is an ordinary instruction, goes to EXEC, and `carry` is unused.

## Structure
- Package `cpu_pkg` holds:
  - the state enum: FETCH, DECODE, EXEC, HALT
  - opcode constants: `OP_JMP=4'hB`, `OP_JC=4'hC`, `OP_HLT=4'hF`
  - `ADDR_W` and `INSTR_W` default constants
- Sub-module `program_counter` is natural: a 4-bit register with `load`, `load_val`, `inc` and `en`; `load` has priority over `inc`.

## Test plan
- Reset, then `en=1`, RAM returns `8'h08` at address 0, `exec_ready=1` → `ram_addr=0`, `exec_valid` pulses on cycle 3 with `opcode=0`, `operand=8`, and `pc=1` on cycle 4.
- RAM returns `8'hB3` at address 9 → no `exec_valid`, and `pc=3` two enabled cycles after `ram_addr=9`.
- JC `8'hC5` with `carry=1` → `pc=5`. JC `8'hC5` with `carry=0` → `pc` increments. With `FETCH_COND_JUMP_EN` undefined, the same instruction asserts `exec_valid`.
- `exec_ready` held low for 4 cycles in EXEC → `exec_valid` stays high and `ir` and `pc` are stable; `exec_ready=1` → `pc` increments once.
- Ordinary instruction at `pc=4'hF` → `pc` wraps to 0. `8'hF0` fetched → `halted=1` and `pc` frozen until `rst_n` pulses low.
- `rst_n` asserted during EXEC → `exec_valid`, `pc` and `ir` go to 0 before the next clock edge.
